// File: rtl/brick_field_if.sv
// -----------------------------------------------------------------------------
// brick_field_if
//
// Purpose : groups the frame-rate signals exchanged between brick_field, the
//           ball-motion logic and color_mapper. Clk and Reset stay plain ports
//           on the module.
//
// Protocol (the only "handshake" on this bus):
//   - frame_clk is a level strobe synchronous to Clk. Its rising edge, seen
//     while brick_field is idle, starts one scan. Edges seen mid-scan are
//     dropped, there is no ready/back-pressure. BallX/BallY/Ball_size only
//     need to be stable in the cycle that edge is detected.
//   - hit_x / hit_y are single-cycle pulses with no acknowledge. At most one
//     of them is high in any cycle.
//   - new_level is a synchronous request that is honoured in any cycle.
//
// Modports:
//   master : the side that drives the ball/frame inputs (ball logic / bench)
//   slave  : brick_field itself
//
// Signals:
//   frame_clk, new_level        : control inputs to brick_field
//   BallX, BallY, Ball_size     : ball centre and radius, unsigned pixels
//   Block_Array[32:0]           : live-brick map, bit 32 always 0
//   Block_SizeX, Block_SizeY    : brick half extents for color_mapper
//   hit_x, hit_y                : bounce pulses
//   Score, bricks_left, cleared : game bookkeeping
//   fsm_state                   : scan FSM state (0 idle, 1 scan, 2 report)
// -----------------------------------------------------------------------------
interface brick_field_if #(
  parameter int SCORE_W = 16
) ();

  logic               frame_clk;
  logic               new_level;
  logic [9:0]         BallX;
  logic [9:0]         BallY;
  logic [9:0]         Ball_size;
  logic [32:0]        Block_Array;
  logic [9:0]         Block_SizeX;
  logic [9:0]         Block_SizeY;
  logic               hit_x;
  logic               hit_y;
  logic [SCORE_W-1:0] Score;
  logic [5:0]         bricks_left;
  logic               cleared;
  logic [1:0]         fsm_state;

  modport master (
    output frame_clk, new_level, BallX, BallY, Ball_size,
    input  Block_Array, Block_SizeX, Block_SizeY, hit_x, hit_y,
    input  Score, bricks_left, cleared, fsm_state
  );

  modport slave (
    input  frame_clk, new_level, BallX, BallY, Ball_size,
    output Block_Array, Block_SizeX, Block_SizeY, hit_x, hit_y,
    output Score, bricks_left, cleared, fsm_state
  );

endinterface

// File: rtl/brick_field.sv
// -----------------------------------------------------------------------------
// brick_field
//
// Purpose : keeps the live/dead map of the 8 x 4 brick wall and, once per
//           video frame, scans the bricks in index order looking for the first
//           live brick the ball overlaps. That brick is destroyed, the score
//           and live count are updated, and a one-cycle bounce pulse (hit_x or
//           hit_y) is returned to the ball-motion logic.
//
// Brick i geometry: centre X = (i%8)*80 + 40, centre Y = 10 + 20*(i>>3).
//
// Parameters:
//   HALF_W  : brick half width  (drives Block_SizeX)
//   HALF_H  : brick half height (drives Block_SizeY)
//   SCORE_W : score counter width (must be at least 3)
//
// Ports:
//   Clk   : system clock
//   Reset : asynchronous, active-high reset
//   bus   : brick_field_if.slave, see the interface file for signal list
//
// Configuration macro:
//   BRICK_FIELD_ROW_SCORE_EN : when defined, a hit adds 4 - row to Score
//                              (top row 4, bottom row 1); otherwise each hit
//                              adds 1. Nothing else changes.
//
// Timing (E = cycle the frame edge is seen):
//   brick i tested in E+1+i; on a hit the map/score/count change and the pulse
//   is high in E+2+i; idle again from E+3+i. A scan with no hit reports in
//   E+33 and is idle from E+34.
// -----------------------------------------------------------------------------
module brick_field #(
  parameter int HALF_W  = 38,
  parameter int HALF_H  = 8,
  parameter int SCORE_W = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  brick_field_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic               frame_clk_d;
  logic               frame_edge;
  logic [4:0]         idx;
  logic [9:0]         ball_x_q;
  logic [9:0]         ball_y_q;
  logic [9:0]         ball_r_q;
  logic [31:0]        alive;
  logic [SCORE_W-1:0] score;
  logic [5:0]         left;
  logic               hit_x_q;
  logic               hit_y_q;
  logic               cleared_w;

  // Geometry of the brick under test, all in 12 bits so the additive form of
  // the overlap test can never wrap (max 1023 + 1023 + HALF_W).
  logic [11:0] bx, by, br, hw, hh, cx, cy;
  logic        overlap_x;
  logic        overlap_y;
  logic        brick_hit;
  logic        vertical;

  logic [2:0]         weight;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  assign frame_edge = bus.frame_clk & ~frame_clk_d;
  assign cleared_w  = (left == 6'd0);

  assign bx = {2'b00, ball_x_q};
  assign by = {2'b00, ball_y_q};
  assign br = {2'b00, ball_r_q};
  assign hw = 12'(HALF_W);
  assign hh = 12'(HALF_H);
  assign cx = 12'(idx[2:0]) * 12'd80 + 12'd40;
  assign cy = 12'(idx[4:3]) * 12'd20 + 12'd10;

  assign overlap_x = (bx + hw + br >= cx) && (cx + hw + br >= bx);
  assign overlap_y = (by + hh + br >= cy) && (cy + hh + br >= by);

  // A wall with nothing left can still be scanned, it just never hits.
  assign brick_hit = (state == SCAN) && alive[idx] && overlap_x && overlap_y
                     && !cleared_w;

  // Ball centre above or below the brick's vertical extent means it struck a
  // top/bottom face. by + hh < cy is the underflow-free form of by < cy - hh.
  assign vertical = (by + hh < cy) || (by > cy + hh);

`ifdef BRICK_FIELD_ROW_SCORE_EN
  assign weight = 3'd4 - {1'b0, idx[4:3]};
`else
  assign weight = 3'd1;
`endif

  // One extra bit catches the carry so the score sticks at all-ones.
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(weight);
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (frame_edge) state_nx = SCAN;
      end
      SCAN: begin
        if (brick_hit || (idx == 5'd31)) state_nx = REPORT;
      end
      REPORT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // A level restart aborts whatever scan is in flight.
    if (bus.new_level) state_nx = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_d <= 1'b0;
      idx         <= 5'd0;
      ball_x_q    <= 10'd0;
      ball_y_q    <= 10'd0;
      ball_r_q    <= 10'd0;
      alive       <= 32'hFFFF_FFFF;
      score       <= '0;
      left        <= 6'd32;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
    end else begin
      frame_clk_d <= bus.frame_clk;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;

      if ((state == IDLE) && frame_edge) begin
        ball_x_q <= bus.BallX;
        ball_y_q <= bus.BallY;
        ball_r_q <= bus.Ball_size;
        idx      <= 5'd0;
      end else if ((state == SCAN) && !brick_hit) begin
        idx <= idx + 5'd1;
      end

      // new_level takes priority over a same-cycle hit: no brick lost, no
      // points awarded, no pulse.
      if (bus.new_level) begin
        alive <= 32'hFFFF_FFFF;
        left  <= 6'd32;
      end else if (brick_hit) begin
        alive[idx] <= 1'b0;
        score      <= score_next;
        left       <= left - 6'd1;
        hit_y_q    <= vertical;
        hit_x_q    <= ~vertical;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Block_Array = {1'b0, alive};
  assign bus.Block_SizeX = 10'(HALF_W);
  assign bus.Block_SizeY = 10'(HALF_H);
  assign bus.hit_x       = hit_x_q;
  assign bus.hit_y       = hit_y_q;
  assign bus.Score       = score;
  assign bus.bricks_left = left;
  assign bus.cleared     = cleared_w;
  assign bus.fsm_state   = state;

endmodule
